// File: rtl/audio_mixer_seq.sv
// Multi-channel sample sequencer/mixer between the codec handshake and the sample ROM.
// Optional overrun counter port: define AUDIO_MIXER_OVERRUN_CNT_EN.
module audio_mixer_seq #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16,
  parameter int DIV_W  = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     INIT_FINISH,
  output logic                     INIT,
  input  logic                     data_over,
  input  logic [NUM_CH-1:0]        ch_start,
  input  logic [NUM_CH-1:0]        ch_loop,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base,
  input  logic [NUM_CH*ADDR_W-1:0] ch_len,
  input  logic [NUM_CH*DIV_W-1:0]  ch_div,
  output logic [NUM_CH-1:0]        ch_active,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  output logic [DATA_W-1:0]        sample_out,
  output logic                     sample_valid
`ifdef AUDIO_MIXER_OVERRUN_CNT_EN
  ,
  output logic [7:0]               overrun_cnt
`endif
);

  localparam int ACC_W = DATA_W + $clog2(NUM_CH) + 1;
  localparam int CNT_W = $clog2(NUM_CH + 1);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_MIX  = 2'd2
  } state_t;

  state_t                    state_r;
  logic [CNT_W-1:0]          mix_cnt_r;
  logic                      init_r;
  logic [NUM_CH-1:0]         active_r;
  logic [NUM_CH-1:0]         done_r;
  logic [ADDR_W-1:0]         offset_r [NUM_CH];
  logic [DIV_W-1:0]          rate_r [NUM_CH];
  logic                      mem_rd_r;
  logic                      rd_d_r;
  logic [ADDR_W-1:0]         mem_addr_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic [DATA_W-1:0]         sample_out_r;
  logic                      sample_valid_r;

  logic [ADDR_W-1:0]         base_s [NUM_CH];
  logic [ADDR_W-1:0]         len_s [NUM_CH];
  logic [DIV_W-1:0]          div_s [NUM_CH];
  logic [NUM_CH-1:0]         start_s;
  logic [NUM_CH-1:0]         act_nxt_s;
  logic [NUM_CH-1:0]         done_nxt_s;
  logic [ADDR_W-1:0]         off_nxt_s [NUM_CH];
  logic [DIV_W-1:0]          rate_nxt_s [NUM_CH];
  logic [ADDR_W-1:0]         addr_nxt_s [NUM_CH];
  logic                      rd_go_s;
  logic [IDX_W-1:0]          rd_idx_s;
  logic signed [ACC_W-1:0]   data_ext_s;
  logic signed [ACC_W-1:0]   acc_sum_s;

  function automatic logic [DATA_W-1:0] sat_f(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    lo = ~hi;
    if (v > hi) begin
      sat_f = hi[DATA_W-1:0];
    end else if (v < lo) begin
      sat_f = lo[DATA_W-1:0];
    end else begin
      sat_f = v[DATA_W-1:0];
    end
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign base_s[g]  = ch_base[g*ADDR_W +: ADDR_W];
    assign len_s[g]   = ch_len[g*ADDR_W +: ADDR_W];
    assign div_s[g]   = ch_div[g*DIV_W +: DIV_W];
    assign start_s[g] = ch_start[g] && (state_r != ST_WAIT) && (len_s[g] != '0);
  end

  // Next channel state; reads address channels with these values so each read sees its own cycle's offset
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      act_nxt_s[k]  = active_r[k];
      done_nxt_s[k] = 1'b0;
      off_nxt_s[k]  = offset_r[k];
      rate_nxt_s[k] = rate_r[k];
      if (start_s[k]) begin
        act_nxt_s[k]  = 1'b1;
        off_nxt_s[k]  = '0;
        rate_nxt_s[k] = '0;
      end else if (active_r[k]) begin
        if (rate_r[k] == div_s[k]) begin
          rate_nxt_s[k] = '0;
          if (offset_r[k] == len_s[k] - ADDR_W'(1'b1)) begin
            off_nxt_s[k] = '0;
            if (ch_loop[k]) begin
              act_nxt_s[k] = 1'b1;
            end else begin
              act_nxt_s[k]  = 1'b0;
              done_nxt_s[k] = 1'b1;
            end
          end else begin
            off_nxt_s[k] = offset_r[k] + ADDR_W'(1'b1);
          end
        end else begin
          rate_nxt_s[k] = rate_r[k] + DIV_W'(1'b1);
        end
      end else begin
        act_nxt_s[k] = 1'b0;
      end
      addr_nxt_s[k] = base_s[k] + off_nxt_s[k];
    end
  end

  // Pick which channel is read in the coming cycle of a mix
  always_comb begin
    rd_go_s  = 1'b0;
    rd_idx_s = '0;
    if ((state_r == ST_IDLE) && data_over) begin
      rd_go_s = 1'b1;
    end else if ((state_r == ST_MIX) && (mix_cnt_r < CNT_W'(NUM_CH - 1))) begin
      rd_go_s  = 1'b1;
      rd_idx_s = IDX_W'(mix_cnt_r + CNT_W'(1'b1));
    end else begin
      rd_go_s = 1'b0;
    end
  end

  // Running sum including the ROM word returned this cycle
  always_comb begin
    data_ext_s = {{(ACC_W-DATA_W){mem_data[DATA_W-1]}}, mem_data};
    if (rd_d_r) begin
      acc_sum_s = acc_r + data_ext_s;
    end else begin
      acc_sum_s = acc_r;
    end
  end

  // Per-channel playback registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      active_r <= '0;
      done_r   <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        offset_r[k] <= '0;
        rate_r[k]   <= '0;
      end
    end else begin
      active_r <= act_nxt_s;
      done_r   <= done_nxt_s;
      for (int k = 0; k < NUM_CH; k++) begin
        offset_r[k] <= off_nxt_s[k];
        rate_r[k]   <= rate_nxt_s[k];
      end
    end
  end

  // Top FSM with ROM port, accumulator and mixed output
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r        <= ST_WAIT;
      mix_cnt_r      <= '0;
      init_r         <= 1'b1;
      mem_rd_r       <= 1'b0;
      rd_d_r         <= 1'b0;
      mem_addr_r     <= '0;
      acc_r          <= '0;
      sample_out_r   <= '0;
      sample_valid_r <= 1'b0;
`ifdef AUDIO_MIXER_OVERRUN_CNT_EN
      overrun_cnt    <= 8'd0;
`endif
    end else begin
      mem_rd_r       <= rd_go_s & act_nxt_s[rd_idx_s];
      rd_d_r         <= mem_rd_r;
      sample_valid_r <= 1'b0;
      acc_r          <= acc_sum_s;
      if (rd_go_s) begin
        mem_addr_r <= addr_nxt_s[rd_idx_s];
      end
      case (state_r)
        ST_WAIT: begin
          init_r <= 1'b1;
          if (INIT_FINISH) begin
            state_r <= ST_IDLE;
            init_r  <= 1'b0;
          end
        end
        ST_IDLE: begin
          init_r <= 1'b0;
          if (data_over) begin
            state_r   <= ST_MIX;
            mix_cnt_r <= '0;
          end
        end
        ST_MIX: begin
          init_r <= 1'b0;
          if (mix_cnt_r == CNT_W'(NUM_CH)) begin
            state_r        <= ST_IDLE;
            mix_cnt_r      <= '0;
            sample_out_r   <= sat_f(acc_sum_s);
            sample_valid_r <= 1'b1;
            acc_r          <= '0;
          end else begin
            mix_cnt_r <= mix_cnt_r + CNT_W'(1'b1);
          end
`ifdef AUDIO_MIXER_OVERRUN_CNT_EN
          if (data_over && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
          end
`endif
        end
        default: begin
          state_r   <= ST_WAIT;
          mix_cnt_r <= '0;
          init_r    <= 1'b1;
        end
      endcase
    end
  end

  assign INIT         = init_r;
  assign ch_active    = active_r;
  assign ch_done      = done_r;
  assign mem_rd       = mem_rd_r;
  assign mem_addr     = mem_addr_r;
  assign sample_out   = sample_out_r;
  assign sample_valid = sample_valid_r;

endmodule

// File: tb/tb_audio_mixer_seq.sv
// Scoreboard bench for audio_mixer_seq (NUM_CH=4): expected mixes are queued when
// data_over is driven and compared, with their due cycle, when sample_valid fires.
module tb_audio_mixer_seq;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        INIT_FINISH;
  logic        INIT;
  logic        data_over;
  logic [3:0]  ch_start;
  logic [3:0]  ch_loop;
  logic [67:0] ch_base;
  logic [67:0] ch_len;
  logic [63:0] ch_div;
  logic [3:0]  ch_active;
  logic [3:0]  ch_done;
  logic        mem_rd;
  logic [16:0] mem_addr;
  logic [15:0] mem_data;
  logic [15:0] sample_out;
  logic        sample_valid;
`ifdef AUDIO_MIXER_OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif

  typedef struct { logic [15:0] val; int due; } sb_t;
  typedef struct { int cyc; logic [16:0] addr; } rd_t;

  sb_t         sb_q[$];
  rd_t         rd_q[$];
  logic [15:0] rom [0:131071];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  audio_mixer_seq dut (
    .Clk(Clk), .Reset(Reset), .INIT_FINISH(INIT_FINISH), .INIT(INIT),
    .data_over(data_over), .ch_start(ch_start), .ch_loop(ch_loop),
    .ch_base(ch_base), .ch_len(ch_len), .ch_div(ch_div),
    .ch_active(ch_active), .ch_done(ch_done), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_data(mem_data), .sample_out(sample_out),
    .sample_valid(sample_valid)
`ifdef AUDIO_MIXER_OVERRUN_CNT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  // ROM answers one cycle after the strobe; junk otherwise so stray adds show up
  always @(posedge Clk) mem_data <= mem_rd ? rom[mem_addr] : 16'hDEAD;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      if (mem_rd) rd_q.push_back('{cyc, mem_addr});
      if (sample_valid) begin
        if (sb_q.size() == 0) begin
          check_val("unexp_valid", 32'(sb_q.size()), 32'd1);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check_val("sample", 32'(sample_out), 32'(e.val));
          check_val("latency", cyc, e.due);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] st, input logic dov, input logic push, input logic [15:0] exp);
    ch_start  = st;
    data_over = dov;
    if (push) sb_q.push_back('{exp, cyc + 6});
    tick(1);
    ch_start  = 4'b0000;
    data_over = 1'b0;
  endtask

  task automatic set_ch(input int k, input int base, input int len, input int div, input logic lp);
    ch_base[k*17 +: 17] = base[16:0];
    ch_len[k*17 +: 17]  = len[16:0];
    ch_div[k*16 +: 16]  = div[15:0];
    ch_loop[k]          = lp;
  endtask

  task automatic chk_rd(input string tag, input int exp_cyc, input logic [16:0] exp_addr);
    rd_t r;
    if (rd_q.size() > 0) begin
      r = rd_q.pop_front();
      check_val({tag, "_cyc"}, r.cyc, exp_cyc);
      check_val({tag, "_addr"}, 32'(r.addr), 32'(exp_addr));
    end else begin
      check_val({tag, "_none"}, 32'(rd_q.size()), 32'd1);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    tick(3);
  endtask

  logic [15:0] sat_rom [6][4];
  logic [15:0] sat_exp [6];

  initial begin
    int s;
    int t;
    int off;
    logic [16:0] a;

    for (int i = 0; i < 131072; i++) rom[i] = 16'h0000;
    rom[100] = 16'd10; rom[101] = 16'd20; rom[102] = 16'd30;
    rom[17'h1FFFE] = 16'd1000; rom[17'h1FFFF] = 16'd2000;
    rom[0] = 16'd3000; rom[1] = 16'd4000;
    rom[600] = 16'd5; rom[601] = 16'd5; rom[700] = 16'd7; rom[701] = 16'd7;
    sat_rom = '{'{16'h7000, 16'h7000, 16'h7000, 16'h7000},
                '{16'h9000, 16'h9000, 16'h9000, 16'h9000},
                '{16'h4000, 16'h3000, 16'hF000, 16'h0100},
                '{16'h7FFF, 16'h0001, 16'h0000, 16'h0000},
                '{16'h8000, 16'hFFFF, 16'h0000, 16'h0000},
                '{16'h8000, 16'h7FFF, 16'h0000, 16'h0000}};
    sat_exp = '{16'h7FFF, 16'h8000, 16'h6100, 16'h7FFF, 16'h8000, 16'hFFFF};

    Reset = 1'b1; INIT_FINISH = 1'b0; data_over = 1'b0;
    ch_start = 4'b0; ch_loop = 4'b0; ch_base = '0; ch_len = '0; ch_div = '0;
    set_ch(0, 100, 3, 0, 1'b0);
    tick(3);
    check_val("rst_init", 32'(INIT), 32'd1);
    check_val("rst_active", 32'(ch_active), 32'd0);
    check_val("rst_done", 32'(ch_done), 32'd0);
    check_val("rst_rd", 32'(mem_rd), 32'd0);
    check_val("rst_addr", 32'(mem_addr), 32'd0);
    check_val("rst_out", 32'(sample_out), 32'd0);
    check_val("rst_valid", 32'(sample_valid), 32'd0);

    // WAIT ignores starts and sample requests until the codec is up
    Reset = 1'b0;
    tick(2);
    rd_q.delete();
    pulse(4'b0001, 1'b1, 1'b0, 16'h0);
    tick(7);
    check_val("wait_rd", 32'(rd_q.size()), 32'd0);
    check_val("wait_active", 32'(ch_active), 32'd0);
    check_val("wait_init", 32'(INIT), 32'd1);
    INIT_FINISH = 1'b1;
    check_val("init_hold", 32'(INIT), 32'd1);
    tick(1);
    check_val("init_clear", 32'(INIT), 32'd0);
    tick(1);

    // single channel: the sample follows the offset present at the read
    rd_q.delete();
    s = cyc;
    pulse(4'b0001, 1'b1, 1'b1, 16'd10);
    check_val("one_active", 32'(ch_active), 32'd1);
    tick(2);
    check_val("one_nodone", 32'(ch_done), 32'd0);
    tick(1);
    check_val("one_done", 32'(ch_done), 32'd1);
    check_val("one_ended", 32'(ch_active), 32'd0);
    tick(1);
    check_val("one_done_pulse", 32'(ch_done), 32'd0);
    tick(4);
    check_val("one_rd_n", 32'(rd_q.size()), 32'd1);
    chk_rd("one_rd", s + 1, 17'd100);
    pulse(4'b0001, 1'b0, 1'b0, 16'h0);
    pulse(4'b0000, 1'b1, 1'b1, 16'd20);
    tick(8);
    pulse(4'b0001, 1'b0, 1'b0, 16'h0);
    tick(1);
    pulse(4'b0000, 1'b1, 1'b1, 16'd30);
    tick(8);
    rd_q.delete();
    pulse(4'b0000, 1'b1, 1'b1, 16'd0);
    tick(8);
    check_val("idle_rd", 32'(rd_q.size()), 32'd0);

    // retrigger on the very cycle the channel ends
    s = cyc;
    pulse(4'b0001, 1'b0, 1'b0, 16'h0);
    tick(2);
    pulse(4'b0001, 1'b1, 1'b1, 16'd10);
    check_val("retrig_active", 32'(ch_active), 32'd1);
    check_val("retrig_nodone", 32'(ch_done), 32'd0);
    tick(3);
    check_val("retrig_end", 32'(ch_done), 32'd1);
    tick(6);

    // second request inside a mix is dropped
    rd_q.delete();
    pulse(4'b0000, 1'b1, 1'b1, 16'd0);
    tick(1);
    pulse(4'b0000, 1'b1, 1'b0, 16'h0);
    tick(8);
    check_val("ovr_rd", 32'(rd_q.size()), 32'd0);
`ifdef AUDIO_MIXER_OVERRUN_CNT_EN
    check_val("ovr_cnt", 32'(overrun_cnt), 32'd1);
`endif

    set_ch(2, 0, 0, 0, 1'b0);
    pulse(4'b0100, 1'b0, 1'b0, 16'h0);
    check_val("len0_ignored", 32'(ch_active), 32'd0);

    // looping channel with divider, address wraps through 2^17
    set_ch(1, 17'h1FFFE, 4, 3, 1'b1);
    s = cyc;
    pulse(4'b0010, 1'b0, 1'b0, 16'h0);
    for (int j = 0; j < 6; j++) begin
      off = ((2 + 6 * j) / 4) % 4;
      a = 17'h1FFFE + off[16:0];
      rd_q.delete();
      t = cyc;
      pulse(4'b0000, 1'b1, 1'b1, rom[a]);
      tick(5);
      check_val("loop_rd_n", 32'(rd_q.size()), 32'd1);
      chk_rd("loop_rd", t + 2, a);
    end

    // reset in the middle of a mix and of playback
    pulse(4'b0000, 1'b1, 1'b0, 16'h0);
    Reset = 1'b1;
    tick(1);
    check_val("mid_rst_active", 32'(ch_active), 32'd0);
    check_val("mid_rst_init", 32'(INIT), 32'd1);
    check_val("mid_rst_rd", 32'(mem_rd), 32'd0);
    check_val("mid_rst_valid", 32'(sample_valid), 32'd0);
`ifdef AUDIO_MIXER_OVERRUN_CNT_EN
    check_val("mid_rst_ovr", 32'(overrun_cnt), 32'd0);
`endif
    Reset = 1'b0;
    tick(10);
    check_val("post_rst_init", 32'(INIT), 32'd0);

    // latency with two active channels
    set_ch(0, 600, 2, 0, 1'b1);
    set_ch(1, 700, 2, 0, 1'b1);
    s = cyc;
    pulse(4'b0011, 1'b0, 1'b0, 16'h0);
    tick(2);
    rd_q.delete();
    t = cyc;
    pulse(4'b0000, 1'b1, 1'b1, 16'd12);
    tick(7);
    check_val("lat_rd_n", 32'(rd_q.size()), 32'd2);
    chk_rd("lat_rd0", t + 1, 17'(600 + ((t - s) % 2)));
    chk_rd("lat_rd1", t + 2, 17'(700 + ((t + 1 - s) % 2)));

    // saturation and signed mixing over all four channels
    do_reset();
    for (int k = 0; k < 4; k++) set_ch(k, 200 + 10 * k, 2, 0, 1'b1);
    pulse(4'b1111, 1'b0, 1'b0, 16'h0);
    tick(2);
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 4; k++) begin
        rom[200 + 10 * k] = sat_rom[v][k];
        rom[201 + 10 * k] = sat_rom[v][k];
      end
      pulse(4'b0000, 1'b1, 1'b1, sat_exp[v]);
      tick(8);
      check_val("sat_hold", 32'(sample_out), 32'(sat_exp[v]));
    end

    tick(10);
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_mixer_seq.md
Name: audio_mixer_seq

Overview:
- Parametrised multi-channel successor to the single-stream sample-address sequencer.
- Runs NUM_CH independent sample channels. Each channel has its own base address, length, rate divider and loop mode.
- On each codec sample request, reads one sample per active channel from a shared sample ROM, then sums and saturates them into one output sample.
- Sits between the codec init/handshake logic and the on-chip sample ROM.

Parameters:
NUM_CH, 4, number of playback channels (1..8)
ADDR_W, 17, sample ROM address width
DATA_W, 16, signed sample width
DIV_W, 16, rate-divider width

Ports:
Clk  in  1  clock
Reset  in  1  reset
INIT_FINISH  in  1  codec initialisation complete (level)
INIT  out  1  codec init request
data_over  in  1  codec sample request, single-cycle pulse
ch_start  in  NUM_CH  per-channel start/retrigger pulse
ch_loop  in  NUM_CH  per-channel loop enable (level, sampled at wrap)
ch_base  in  NUM_CH*ADDR_W  per-channel base address; channel k occupies bits [k*ADDR_W +: ADDR_W]
ch_len  in  NUM_CH*ADDR_W  per-channel length in samples
ch_div  in  NUM_CH*DIV_W  per-channel advance period minus 1, in Clk cycles
ch_active  out  NUM_CH  channel currently playing
ch_done  out  NUM_CH  one-cycle pulse when a non-looping channel ends
mem_rd  out  1  ROM read strobe
mem_addr  out  ADDR_W  ROM read address
mem_data  in  DATA_W  ROM data, valid exactly 1 cycle after mem_rd
sample_out  out  DATA_W  mixed signed sample (registered)
sample_valid  out  1  one-cycle pulse when sample_out updates

Behaviour:
- Reset is synchronous and active-high; clock is Clk.
- Reset values:
  - State WAIT, INIT=1.
  - ch_active=0, ch_done=0, mem_rd=0, mem_addr=0.
  - sample_out=0, sample_valid=0.
  - All offsets, rate counters and the accumulator are 0.
- Reset asserted mid-mix or mid-playback aborts everything to these values on the next edge.
- Top FSM:
  - WAIT: INIT=1. When INIT_FINISH=1 is sampled, go to IDLE next cycle.
  - IDLE: INIT=0. data_over=1 goes to MIX.
  - MIX: lasts NUM_CH+1 cycles, then returns to IDLE.
  - Nothing returns to WAIT except Reset.
- In WAIT, ch_start and data_over are ignored.
- Channel k start:
  - In IDLE/MIX, ch_start[k]=1 sets ch_active[k]=1 next cycle, with offset=0 and rate counter=0.
  - A retrigger while active restarts the channel the same way.
  - If ch_len[k]=0, the start is ignored.
- Channel advance (active channels):
  - The rate counter increments each cycle.
  - When counter==ch_div[k]: counter->0 and the offset advances.
  - ch_div=0 means advance every cycle.
- End of sample, when advancing from offset==ch_len-1:
  - If ch_loop[k]=1: offset->0.
  - Otherwise: ch_active[k]->0 and ch_done[k] pulses for 1 cycle.
- A start and an end on the same cycle: start wins, and ch_done is not pulsed.
- Address: mem_addr = ch_base[k] + offset[k], modulo 2^ADDR_W (wraps, no error).
- MIX timing, with data_over sampled at cycle t:
  - Cycle t+1+k, k=0..NUM_CH-1: mem_addr = address of channel k; mem_rd = ch_active[k].
  - Inactive channels issue no read and contribute 0.
  - Cycle t+2+k: if the read was issued, mem_data is sign-extended and added to the accumulator. The accumulator width is DATA_W+clog2(NUM_CH)+1.
  - Cycle t+NUM_CH+2: sample_out = accumulator saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; sample_valid=1; accumulator cleared. Latency is NUM_CH+2 cycles.
- No channels active: mixing still runs and sample_out=0 with sample_valid pulsed.
- data_over during MIX is dropped; no queueing.
- Offsets keep advancing during MIX. Each read uses the offset value present in its own read cycle.
- sample_out holds its value between sample_valid pulses.

Optional Feature:
- Macro: AUDIO_MIXER_OVERRUN_CNT_EN.
- Defined:
  - Adds output port overrun_cnt (8 bits), reset 0.
  - It increments on each data_over dropped during MIX and saturates at 255.
  - It clears only on Reset.
- Undefined: the port and counter do not exist; dropped requests are silent.

Test Plan:
- Init handshake: Reset, then INIT_FINISH=1 at cycle 5 -> INIT=1 through cycle 5, INIT=0 from cycle 6. A data_over at cycle 3 produces no mem_rd and no sample_valid.
- Single channel mixing (NUM_CH=4):
  - Setup: ch0 base=100, len=3, div=0, loop=0; ROM[100..102] = 10, 20, 30.
  - Stimulus: start, then data_over every 8 cycles.
  - Response: sample_out follows the current offset; ch_done[0] pulses after offset 2 advances; later samples = 0.
- Looping with divider: ch1 base=0x1FFFE, len=4, div=3, loop=1 -> offset advances every 4 cycles. mem_addr sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001, then repeats.
- Saturation: ch0..ch3 active with ROM samples 0x7000 each -> sample_out=0x7FFF. With 0x9000 each -> sample_out=0x8000.
- Latency: data_over at cycle t with 2 active channels -> mem_rd at t+1 and t+2 only; sample_valid exactly at t+6 (NUM_CH=4).
- Retrigger and overrun:
  - ch_start[0] on the same cycle as its end -> ch_active stays 1, offset=0, no ch_done.
  - data_over at t and t+2 -> the second is dropped; overrun_cnt=1 when AUDIO_MIXER_OVERRUN_CNT_EN is defined.
